sfp_tx_framer: RTL and testbench
================================

// Module: sfp_tx_framer
// PURPOSE
// Framing stage directly downstream of the SFP handler TX stream and upstream of the 64-bit SFP transceiver AXIS port.
// Groups handler payload words into frames: a header word, up to FRAME_WORDS payload words, then a trailer word.
// The trailer carries the payload length and a 32-bit checksum. The far-end deframer uses these to detect loss and corruption.
// Closes a partial frame on an idle timeout or on disable, so telemetry latency stays bounded.
// PARAMETERS
// FRAME_WORDS   9        max payload words per frame (1..255)
// IDLE_TIMEOUT  64       idle cycles, with no input word, before a partial frame is closed (1..65535)
// HDR_SYNC      16'hA55A header sync field
// TRL_SYNC      16'h5AA5 trailer sync field
// PORTS
// i_clk           in   1   system clock (~200 MHz)
// i_rst           in   1   asynchronous reset, active-high
// i_en            in   1   framer enable
// i_sfp_id        in   2   node ID placed in header
// s_axis_tdata    in   64  payload from SFP handler
// s_axis_tvalid   in   1   payload valid
// s_axis_tready   out  1   payload accept
// m_axis_tdata    out  64  framed stream to transceiver
// m_axis_tvalid   out  1   framed word valid
// m_axis_tready   in   1   transceiver accept
// o_busy          out  1   frame in progress (state != IDLE)
// o_frame_cnt     out  32  completed frames (trailer accepted); wraps
// BEHAVIOUR
// Reset: state=IDLE; seq, counters, checksum, o_frame_cnt = 0; m_axis_tvalid, s_axis_tready, o_busy = 0; m_axis_tdata = 0.
// Reset mid-frame: the partial frame is dropped with no trailer; seq restarts at 0.
// Output register: a single 64-bit register plus valid.
//   - Loads when !m_axis_tvalid || m_axis_tready.
//   - Holds data and valid stable while m_axis_tvalid && !m_axis_tready (AXIS rule).
// Header word: {HDR_SYNC, 14'b0, i_sfp_id, seq[15:0], 16'h0000}.
//   - seq increments when the trailer is loaded; wraps 0xFFFF -> 0x0000.
// Trailer word: {TRL_SYNC, len[7:0], 8'h00, csum[31:0]}.
//   - len = number of payload words in the frame (1..FRAME_WORDS).
//   - csum = mod-2^32 sum of tdata[63:32] and tdata[31:0] over every payload word; cleared on header load.
// FSM:
//   - IDLE: s_axis_tready=0. If i_en && s_axis_tvalid, load header into the output register, then go to PAY.
//   - PAY: s_axis_tready = (!m_axis_tvalid || m_axis_tready).
//     - An accepted word loads the output register, len+1, csum+=, idle_cnt=0.
//     - When len reaches FRAME_WORDS, go to TRL.
//     - With no word accepted, idle_cnt+1 (saturating). At idle_cnt==IDLE_TIMEOUT, or !i_en, go to TRL.
//   - TRL: s_axis_tready=0. When the output register can load, load the trailer and go to WAIT.
//   - WAIT: when the trailer is accepted (m_axis_tvalid && m_axis_tready), o_frame_cnt+1 and go to IDLE.
// Latency: header output 1 cycle after the first s_axis_tvalid in IDLE. Payload output 1 cycle after accept.
// Throughput: a full frame is FRAME_WORDS+2 output beats, plus 1 IDLE cycle between frames.
// PAY is always entered with the header in flight, so len>=1 at TRL is not guaranteed by entry alone.
// The rules that keep zero-length frames off the link:
//   - With len==0, the timeout and disable exits are ignored and the FSM stays in PAY.
//   - If i_en drops while len==0, go directly to IDLE with no trailer. The header-only frame is left for the far end to discard.
// Simultaneous events, a word accepted in the same cycle the timeout fires or i_en falls:
//   - The word is included in the frame.
//   - Then go to TRL, or stay in PAY if len<FRAME_WORDS and i_en=1 and no timeout.
// i_sfp_id is sampled only when the header is loaded.
// TESTING
// T1 FRAME_WORDS=9, m_tready=1, stream 9 words 64'h0000_0001_0000_0001 ->
//    output: header(seq=0), 9 payload beats, trailer {5AA5,09,00,0000_0012}; o_frame_cnt=1.
// T2 Send 3 words, then hold s_tvalid=0 for 64 cycles -> trailer len=3 after timeout; next frame header has seq=1.
// T3 Randomly deassert m_tready during header/payload/trailer -> m_tdata stable while stalled; no word lost or duplicated.
// T4 Deassert i_en after 5 payload words; also accept a word in that same cycle -> trailer len=6; FSM returns to IDLE.
// T5 Assert i_rst mid-payload -> all outputs 0 asynchronously; after release, header seq=0.
// T6 Checksum wrap: payload {32'hFFFF_FFFF, 32'h0000_0002} -> csum=32'h0000_0001; seq wraps 0xFFFF->0 after 65536 frames.

Source files
------------

// File: rtl/sfp_tx_framer.sv
// Frames handler payload words as header / payload / trailer beats for the SFP transceiver.
module sfp_tx_framer #(
    parameter int unsigned FRAME_WORDS  = 9,
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter logic [15:0] HDR_SYNC     = 16'hA55A,
    parameter logic [15:0] TRL_SYNC     = 16'h5AA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [1:0]  i_sfp_id,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        o_busy,
    output logic [31:0] o_frame_cnt
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY,
        S_TRL,
        S_WAIT
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [15:0]      seq_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_acc;
    logic [31:0]      csum_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [31:0]      frame_cnt_q;
    logic [63:0]      out_data_q;
    logic             out_valid_q;
    logic             can_load;
    logic             accept;
    logic             load_hdr;
    logic             load_trl;
    logic             trl_done;

    // Output register may take a new word when empty or being drained this cycle.
    assign can_load      = !out_valid_q || m_axis_tready;
    assign accept        = (state_q == S_PAY) && s_axis_tvalid && can_load;
    assign len_acc       = len_q + LEN_W'(accept);
    assign trl_done      = (state_q == S_WAIT) && out_valid_q && m_axis_tready;

    assign s_axis_tready = (state_q == S_PAY) && can_load;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_cnt   = frame_cnt_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and load strobes; zero-length frames never get a trailer.
    always_comb begin
        state_n  = state_q;
        load_hdr = 1'b0;
        load_trl = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_en && s_axis_tvalid && can_load) begin
                    load_hdr = 1'b1;
                    state_n  = S_PAY;
                end
            end
            S_PAY: begin
                if (len_acc == LEN_MAX) begin
                    state_n = S_TRL;
                end else if (!i_en) begin
                    state_n = (len_acc == '0) ? S_IDLE : S_TRL;
                end else if ((idle_cnt_q == TO_VAL) && (len_acc != '0)) begin
                    state_n = S_TRL;
                end
            end
            S_TRL: begin
                if (can_load) begin
                    load_trl = 1'b1;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (trl_done) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output register: header, payload or trailer; holds while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (load_hdr) begin
            out_data_q  <= {HDR_SYNC, 14'd0, i_sfp_id, seq_q, 16'h0000};
            out_valid_q <= 1'b1;
        end else if (load_trl) begin
            out_data_q  <= {TRL_SYNC, len_q, 8'h00, csum_q};
            out_valid_q <= 1'b1;
        end else if (accept) begin
            out_data_q  <= s_axis_tdata;
            out_valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Per-frame length, checksum and idle counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q      <= '0;
            csum_q     <= '0;
            idle_cnt_q <= '0;
        end else if (load_hdr) begin
            len_q      <= '0;
            csum_q     <= '0;
            idle_cnt_q <= '0;
        end else if (accept) begin
            len_q      <= len_acc;
            csum_q     <= csum_q + s_axis_tdata[63:32] + s_axis_tdata[31:0];
            idle_cnt_q <= '0;
        end else if ((state_q == S_PAY) && (idle_cnt_q != '1)) begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end

    // Sequence number advances on trailer load; frame count on trailer accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seq_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (load_trl) begin
                seq_q <= seq_q + 16'd1;
            end
            if (trl_done) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sfp_tx_framer.sv
// Directed and randomized bench for sfp_tx_framer against a frame-level reference model.
module tb_sfp_tx_framer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [1:0]  i_sfp_id;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        o_busy;
    logic [31:0] o_frame_cnt;

    sfp_tx_framer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_sfp_id     (i_sfp_id),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          npass = 0;
    int          ntot  = 0;
    logic [63:0] src[$];
    logic [63:0] exp_q[$];
    logic [63:0] pw[$];
    logic [15:0] seq_m = 16'd0;
    logic [31:0] fc_m  = 32'd0;
    int          acc   = 0;
    logic        hs_in;
    logic        hs_out;
    logic        rnd_ready   = 1'b0;
    logic        force_ready = 1'b1;
    logic        gap         = 1'b0;
    logic        tv_pending  = 1'b0;
    logic        prev_stall  = 1'b0;
    logic [63:0] prev_data   = '0;
    logic [63:0] last_out    = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot = ntot + 1;
        assert (obs === expv) npass = npass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic logic [63:0] hdr_w(input logic [1:0] id, input logic [15:0] s);
        return {16'hA55A, 14'd0, id, s, 16'h0000};
    endfunction

    function automatic logic [63:0] trl_w(input int len, input logic [31:0] cs);
        return {16'h5AA5, 8'(len), 8'h00, cs};
    endfunction

    // Expected frame: header, first k words of pw, trailer; all of pw is offered at the input.
    task automatic plan_frame(input logic [1:0] id, input int k);
        logic [31:0] cs;
        logic [63:0] w;
        cs = 32'd0;
        i_sfp_id = id;
        exp_q.push_back(hdr_w(id, seq_m));
        for (int i = 0; i < k; i++) begin
            w = pw[i];
            exp_q.push_back(w);
            cs = cs + w[63:32] + w[31:0];
        end
        exp_q.push_back(trl_w(k, cs));
        seq_m = seq_m + 16'd1;
        fc_m  = fc_m + 32'd1;
        foreach (pw[i]) src.push_back(pw[i]);
    endtask

    // One clock: drive at negedge, sample 1 time unit later, book handshakes.
    task automatic cyc();
        s_axis_tvalid = (src.size() > 0) && (tv_pending || !gap || ($urandom_range(0, 3) != 0));
        s_axis_tdata  = (src.size() > 0) ? src[0] : 64'd0;
        m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
        #1;
        hs_in  = s_axis_tvalid && s_axis_tready;
        hs_out = m_axis_tvalid && m_axis_tready;
        if (prev_stall) begin
            chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("hold_data", m_axis_tdata, prev_data);
        end
        if (hs_out) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("beat_data", m_axis_tdata, exp_q.pop_front());
            last_out = m_axis_tdata;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        tv_pending = s_axis_tvalid && !hs_in;
        @(negedge i_clk);
        if (hs_in) begin
            void'(src.pop_front());
            acc = acc + 1;
        end
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic fill_rand(input int n);
        pw.delete();
        for (int i = 0; i < n; i++) pw.push_back({$urandom, $urandom});
    endtask

    initial begin
        int g;
        int len_r;
        i_rst = 1'b1; i_en = 1'b1; i_sfp_id = 2'd0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tdata", m_axis_tdata, 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_busy", 64'(o_busy), 64'd0);

        // T1: full frame of constant words, sink always ready.
        pw.delete();
        for (int i = 0; i < 9; i++) pw.push_back(64'h0000_0001_0000_0001);
        plan_frame(2'd1, 9);
        cyc();
        chk("hdr_latency", 64'(m_axis_tvalid), 64'd1);
        run_drain(100);
        chk("t1_trailer", last_out, 64'h5AA5_0900_0000_0012);
        chk("t1_frame_cnt", 64'(o_frame_cnt), 64'(fc_m));

        // T2: three words then idle; closed by timeout.
        fill_rand(3);
        plan_frame(2'd2, 3);
        run_drain(200);
        chk("t2_frame_cnt", 64'(o_frame_cnt), 64'(fc_m));
        chk("t2_idle", 64'(o_busy), 64'd0);

        // T3: random lengths, random sink stalls and source gaps.
        rnd_ready = 1'b1;
        gap = 1'b1;
        for (int f = 0; f < 8; f++) begin
            len_r = $urandom_range(1, 9);
            fill_rand(len_r);
            plan_frame(2'($urandom_range(0, 3)), len_r);
            run_drain(3000);
            chk("t3_frame_cnt", 64'(o_frame_cnt), 64'(fc_m));
        end
        rnd_ready = 1'b0;
        gap = 1'b0;
        force_ready = 1'b1;

        // T4: disable after 5 words while the 6th is accepted in the same cycle.
        fill_rand(9);
        plan_frame(2'd3, 6);
        acc = 0;
        g = 0;
        while (acc < 5 && g < 100) begin
            cyc();
            g++;
        end
        i_en = 1'b0;
        cyc();
        chk("t4_joint_accept", 64'(hs_in), 64'd1);
        run_drain(100);
        chk("t4_idle", 64'(o_busy), 64'd0);
        chk("t4_frame_cnt", 64'(o_frame_cnt), 64'(fc_m));
        src.delete();
        tv_pending = 1'b0;
        i_en = 1'b1;

        // Timeout ignored while no payload word has been taken.
        force_ready = 1'b0;
        fill_rand(1);
        plan_frame(2'd0, 1);
        for (int i = 0; i < 80; i++) cyc();
        chk("len0_timeout_hold", 64'(o_busy), 64'd1);
        force_ready = 1'b1;
        run_drain(200);
        chk("len0_timeout_cnt", 64'(o_frame_cnt), 64'(fc_m));

        // Disable with zero payload: header only, no trailer, seq unchanged.
        force_ready = 1'b0;
        src.push_back(64'hDEAD_BEEF_0BAD_F00D);
        i_sfp_id = 2'd2;
        exp_q.push_back(hdr_w(2'd2, seq_m));
        for (int i = 0; i < 3; i++) cyc();
        i_en = 1'b0;
        cyc();
        cyc();
        chk("len0_drop_idle", 64'(o_busy), 64'd0);
        force_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("len0_drop_hdr_out", 64'(exp_q.size()), 64'd0);
        chk("len0_drop_cnt", 64'(o_frame_cnt), 64'(fc_m));
        src.delete();
        tv_pending = 1'b0;
        i_en = 1'b1;

        // T5: asynchronous reset mid-payload.
        fill_rand(9);
        plan_frame(2'd1, 9);
        acc = 0;
        g = 0;
        while (acc < 3 && g < 100) begin
            cyc();
            g++;
        end
        #2 i_rst = 1'b1;
        #1;
        chk("t5_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t5_m_tdata", m_axis_tdata, 64'd0);
        chk("t5_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd0);
        chk("t5_frame_cnt", 64'(o_frame_cnt), 64'd0);
        exp_q.delete();
        src.delete();
        seq_m = 16'd0;
        fc_m = 32'd0;
        prev_stall = 1'b0;
        tv_pending = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        fill_rand(9);
        plan_frame(2'd2, 9);
        run_drain(100);
        chk("t5_after_cnt", 64'(o_frame_cnt), 64'd1);

        // T6: checksum wraps modulo 2^32.
        pw.delete();
        pw.push_back({32'hFFFF_FFFF, 32'h0000_0002});
        plan_frame(2'd0, 1);
        run_drain(200);
        chk("t6_trailer", last_out, 64'h5AA5_0100_0000_0001);
        chk("t6_frame_cnt", 64'(o_frame_cnt), 64'(fc_m));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
